// File: rtl/simple_io_exerciser.sv
// simple_io_exerciser
// Sequential driver/checker for a 3-input, 2-output gate network with
// out_1 = in_1 & in_2 & in_3 and out_2 = (in_1 & in_2) | in_3.
// On start it walks vectors 0..7, waits SETTLE_CYCLES after driving each one,
// compares the observed outputs against golden values, and reports the result.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start                run request, honoured only in IDLE or DONE
//   obs_out_1/obs_out_2  outputs observed from the network under test
//   drv_in_1..3          registered drives to the network (vec[0..2])
//   busy                 high in SETTLE or CHECK
//   done                 high in DONE
//   pass                 high in DONE when no mismatch was seen
//   err_count            saturating count of mismatching vectors
//   fail_valid/fail_vec  first failing vector, captured once per run
module simple_io_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             obs_out_1,
  input  logic             obs_out_2,
  output logic             drv_in_1,
  output logic             drv_in_2,
  output logic             drv_in_3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t           state, state_nx;
  logic [2:0]       vec, vec_nx;
  logic [3:0]       settle_cnt, settle_cnt_nx;
  logic [ERR_W-1:0] err_nx;
  logic             fail_valid_nx;
  logic [2:0]       fail_vec_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic [1:0]       golden;
  logic             mismatch;

  // Golden response of the network: {out_2, out_1}.
  function automatic logic [1:0] golden_of(input logic [2:0] v);
    golden_of = {(v[0] & v[1]) | v[2], v[0] & v[1] & v[2]};
  endfunction

  // The drive register is the vector index itself, so drives and vec never diverge.
  assign drv_in_1 = vec[0];
  assign drv_in_2 = vec[1];
  assign drv_in_3 = vec[2];

  assign golden   = golden_of(vec);
  assign mismatch = (obs_out_1 != golden[0]) || (obs_out_2 != golden[1]);

  // Next-state, next-result and next-status-flag computation.
  always_comb begin
    state_nx      = state;
    vec_nx        = vec;
    settle_cnt_nx = settle_cnt;
    err_nx        = err_count;
    fail_valid_nx = fail_valid;
    fail_vec_nx   = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          // A start from DONE is identical to one from IDLE: results clear now.
          vec_nx        = 3'd0;
          settle_cnt_nx = 4'd0;
          err_nx        = {ERR_W{1'b0}};
          fail_valid_nx = 1'b0;
          fail_vec_nx   = 3'd0;
          state_nx      = SETTLE;
        end else begin
          state_nx = state;
        end
      end
      SETTLE: begin
        settle_cnt_nx = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          state_nx = CHECK;
        end else begin
          state_nx = SETTLE;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            err_nx = err_count + ERR_W'(1);
          end else begin
            err_nx = err_count;
          end
          if (!fail_valid) begin
            fail_valid_nx = 1'b1;
            fail_vec_nx   = vec;
          end else begin
            fail_valid_nx = fail_valid;
          end
        end else begin
          err_nx = err_count;
        end
        // Exiting at vec 7 keeps vec from ever wrapping within a run.
        if (vec == 3'd7) begin
          state_nx = DONE;
        end else begin
          vec_nx        = vec + 3'd1;
          settle_cnt_nx = 4'd0;
          state_nx      = SETTLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_nx = (state_nx == SETTLE) || (state_nx == CHECK);
    done_nx = (state_nx == DONE);
    pass_nx = (state_nx == DONE) && (err_nx == {ERR_W{1'b0}});
  end

  // State, vector, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 3'd0;
      settle_cnt <= 4'd0;
      err_count  <= {ERR_W{1'b0}};
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nx;
      vec        <= vec_nx;
      settle_cnt <= settle_cnt_nx;
      err_count  <= err_nx;
      fail_valid <= fail_valid_nx;
      fail_vec   <= fail_vec_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
    end
  end

endmodule

// File: doc/simple_io_exerciser.md
Name: simple_io_exerciser

Overview:
- Sequential driver/checker for the 3-input, 2-output AND/OR gate network: out_1 = in_1 & in_2 & in_3, out_2 = (in_1 & in_2) | in_3.
- On a start request it steps all 8 input combinations, waits a settle time after each, compares the observed outputs against golden values, and reports pass/fail, an error count and the first failing vector.
- Sits at the other end of the gate network's port list: it drives the network's inputs and observes its outputs. Used in on-chip self-test and as a reusable bench component.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after driving a vector before sampling; legal range 1..15.
- ERR_W, 4, width of err_count; the count saturates at 2^ERR_W-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- obs_out_1  input  1  observed out_1 from the network under test.
- obs_out_2  input  1  observed out_2 from the network under test.
- drv_in_1  output  1  registered drive to in_1; equals vec[0].
- drv_in_2  output  1  registered drive to in_2; equals vec[1].
- drv_in_3  output  1  registered drive to in_3; equals vec[2].
- busy  output  1  high while in SETTLE or CHECK.
- done  output  1  high while in DONE.
- pass  output  1  high in DONE when err_count == 0; low in every other state.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- fail_valid  output  1  set when the first mismatch is captured.
- fail_vec  output  3  vector index of the first mismatch.

Behaviour:
- Reset, asynchronous:
  - state = IDLE, vec = 0.
  - All outputs 0: drv_in_* = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_valid = 0, fail_vec = 0.
  - Reset asserted mid-run aborts immediately. No partial result is kept.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start = 1:
  - vec <= 0, drv_in_* <= 000, settle_cnt <= 0.
  - err_count <= 0, fail_valid <= 0, fail_vec <= 0.
  - Next state SETTLE.
- IDLE, start = 0: hold.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1, next state is CHECK.
  - Drive outputs stay stable throughout.
- CHECK (exactly one cycle):
  - exp1 = v0 & v1 & v2.
  - exp2 = (v0 & v1) | v2.
  - Mismatch = (obs_out_1 != exp1) or (obs_out_2 != exp2).
  - On mismatch:
    - err_count increments, unless it is already at max (saturates).
    - If fail_valid == 0: fail_vec <= vec, fail_valid <= 1. Later mismatches do not overwrite it.
  - If vec == 7: next state DONE.
  - Otherwise: vec <= vec+1, drv_in_* <= vec+1, settle_cnt <= 0, next state SETTLE.
- DONE:
  - done = 1; pass = (err_count == 0).
  - Results are held and drv_in_* hold 111.
  - start = 1 behaves exactly as start from IDLE: results clear in that cycle and next state is SETTLE.
- start is ignored while busy.
- obs inputs are sampled only in CHECK; values in other states have no effect.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - With default parameters, done rises 8*(2+1) = 24 clock edges after the edge that accepted start.
- Arithmetic: vec is 3 bits and never wraps during a run, because the CHECK at vec == 7 exits to DONE. settle_cnt is 4 bits.
- Simultaneous events: rst dominates every other input.

Test Plan:
- Correct model on obs inputs, SETTLE_CYCLES=2, pulse start:
  - drv_in_* sequence is 000,001,...,111 with each value held 3 cycles.
  - done rises 24 edges after the start edge; pass = 1, err_count = 0, fail_valid = 0.
- obs_out_2 stuck at 0:
  - Mismatches at vectors 3,4,5,6,7 (v2 = 1 or v0&v1).
  - err_count = 5, fail_valid = 1, fail_vec = 3, pass = 0.
- obs_out_1 inverted, ERR_W=2:
  - All 8 vectors mismatch; err_count saturates at 3.
  - fail_vec = 0, pass = 0.
- Assert start repeatedly while busy:
  - Sequence and timing are unchanged.
  - Restart from DONE clears err_count and fail_valid in the cycle start is sampled, and the run repeats.
- Assert rst during SETTLE of vector 4:
  - All outputs go to 0 asynchronously, before the next clock edge.
  - After rst is released, with no start, the block stays in IDLE with drv_in_* = 000.
